// File: rtl/apb_timer_slave.sv
// APB completer timer: prescaled 32-bit down-counter, optional auto-reload, level irq (optional pslverr: APB_TIMER_PSLVERR_EN).
// Latency: pready in DONE, WAIT_STATES+1 cycles after penable rises; writes commit on that edge.
// Backpressure: pready held low through SETUP/WAIT; a master that drops psel aborts with no side effects.
module apb_timer_slave #(
    parameter int WAIT_STATES = 1,
    parameter int PRESCALE_W  = 16
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
`ifdef APB_TIMER_PSLVERR_EN
    output logic        pslverr,
`endif
    output logic        irq
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WAIT, ST_DONE} state_t;

    localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              wait_cnt;

    logic                    ctrl_en;
    logic                    ctrl_irq_en;
    logic                    ctrl_ar;
    logic [31:0]             load_q;
    logic [31:0]             count_q;
    logic                    expired_q;
    logic [PRESCALE_W-1:0]   prescale_q;
    logic [PRESCALE_W-1:0]   pcnt_q;

    logic [7:0]              off;
    logic                    sel_ctrl;
    logic                    sel_load;
    logic                    sel_count;
    logic                    sel_status;
    logic                    sel_prescale;
    logic                    wr_ok;
    logic                    tick;
    logic                    expire;
    logic                    start;
    logic [31:0]             rd_val;
    logic                    unused_addr;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_SETUP && state_nxt == ST_WAIT)
                wait_cnt <= WS_LAST;
            else if (state == ST_WAIT && wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (psel && !penable) state_nxt = ST_SETUP;
            ST_SETUP: if (psel && penable)  state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
            ST_WAIT:  if (wait_cnt == 3'd0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!psel)
            state_nxt = ST_IDLE;
    end

    assign off          = paddr[7:0];
    assign unused_addr  = ^paddr[31:8];
    assign sel_ctrl     = (off == 8'h00);
    assign sel_load     = (off == 8'h04);
    assign sel_count    = (off == 8'h08);
    assign sel_status   = (off == 8'h0C);
    assign sel_prescale = (off == 8'h10);

    assign pready = psel && penable && (state == ST_DONE);

`ifdef APB_TIMER_PSLVERR_EN
    // Misaligned offsets never match the exact-byte decode, so they fall into "unmapped".
    logic err;
    assign err     = !(sel_ctrl || sel_load || sel_count || sel_status || sel_prescale)
                     || (sel_count && pwrite);
    assign pslverr = pready && err;
    assign wr_ok   = pready && pwrite && !err;
`else
    assign wr_ok   = pready && pwrite;
`endif

    assign tick   = ctrl_en && (pcnt_q == prescale_q);
    assign expire = tick && (count_q == 32'd0);
    assign start  = wr_ok && sel_ctrl && pwdata[0] && !ctrl_en;

    // Later assignments win: a CTRL write overrides the one-shot enable clear,
    // and the 0->1 start load overrides a same-cycle decrement.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_ar     <= 1'b0;
            load_q      <= 32'd0;
            count_q     <= 32'd0;
            expired_q   <= 1'b0;
            prescale_q  <= '0;
            pcnt_q      <= '0;
        end else begin
            if (ctrl_en)
                pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
            if (tick) begin
                if (count_q != 32'd0)
                    count_q <= count_q - 32'd1;
                else if (ctrl_ar)
                    count_q <= load_q;
                else
                    ctrl_en <= 1'b0;
            end
            if (expire)
                expired_q <= 1'b1;
            else if (wr_ok && sel_status && pwdata[0])
                expired_q <= 1'b0;
            if (wr_ok && sel_ctrl) begin
                ctrl_en     <= pwdata[0];
                ctrl_irq_en <= pwdata[1];
                ctrl_ar     <= pwdata[2];
            end
            if (start) begin
                count_q <= load_q;
                pcnt_q  <= '0;
            end
            if (wr_ok && sel_load)
                load_q <= pwdata;
            if (wr_ok && sel_prescale)
                prescale_q <= pwdata[PRESCALE_W-1:0];
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (off)
            8'h00:   rd_val = {29'd0, ctrl_ar, ctrl_irq_en, ctrl_en};
            8'h04:   rd_val = load_q;
            8'h08:   rd_val = count_q;
            8'h0C:   rd_val = {31'd0, expired_q};
            8'h10:   rd_val = 32'(prescale_q);
            default: rd_val = 32'd0;
        endcase
    end

    assign prdata = (state == ST_DONE) ? rd_val : 32'd0;
    assign irq    = expired_q && ctrl_irq_en;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: behavioural model plus per-cycle output compare, directed and random APB traffic.
`timescale 1ns/1ps
module tb_apb_timer_slave;
    localparam int WS = 1;
`ifdef APB_TIMER_PSLVERR_EN
    localparam bit HAS_ERR = 1'b1;
`else
    localparam bit HAS_ERR = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready;
    logic        irq;
`ifdef APB_TIMER_PSLVERR_EN
    logic        pslverr;
`endif

    int checks = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    apb_timer_slave #(.WAIT_STATES(WS), .PRESCALE_W(16)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
`ifdef APB_TIMER_PSLVERR_EN
        .pslverr  (pslverr),
`endif
        .irq      (irq)
    );

    // ---------------- behavioural model ----------------
    bit          m_en = 0, m_ie = 0, m_ar = 0, m_exp = 0;
    logic [31:0] m_load = 0, m_count = 0;
    logic [15:0] m_pre = 0, m_ph = 0;
    bit          m_inx = 0;     // inside an accepted transfer
    int          m_acc = 0;     // ACCESS cycles already spent in it

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a, input bit wr);
        bit mapped;
        mapped = (a[7:0] == 8'h00) || (a[7:0] == 8'h04) || (a[7:0] == 8'h08) ||
                 (a[7:0] == 8'h0C) || (a[7:0] == 8'h10);
        return HAS_ERR && (!mapped || (a[7:0] == 8'h08 && wr));
    endfunction

    function automatic logic [31:0] m_reg(input logic [31:0] a);
        case (a[7:0])
            8'h00:   return {29'd0, m_ar, m_ie, m_en};
            8'h04:   return m_load;
            8'h08:   return m_count;
            8'h0C:   return {31'd0, m_exp};
            8'h10:   return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit done, wr, tick, expire;
        bit n_en, n_ie, n_ar, n_exp;
        logic [31:0] n_cnt;
        logic [15:0] n_ph;
        logic [7:0]  off;
        off    = paddr[7:0];
        done   = m_inx && (m_acc == WS + 1) && psel && penable;
        wr     = done && pwrite && !m_err(paddr, pwrite);
        tick   = m_en && (m_ph == m_pre);
        expire = tick && (m_count == 0);
        if (!psel) m_inx = 0;
        else if (!penable) begin m_inx = 1; m_acc = 0; end
        else if (m_inx) begin
            if (done) m_inx = 0;
            else m_acc++;
        end
        n_en = m_en; n_ie = m_ie; n_ar = m_ar; n_exp = m_exp; n_cnt = m_count; n_ph = m_ph;
        if (m_en) n_ph = tick ? 16'd0 : m_ph + 16'd1;
        if (tick) begin
            if (m_count != 0) n_cnt = m_count - 1;
            else if (m_ar) n_cnt = m_load;
            else n_en = 0;
        end
        if (expire) n_exp = 1;
        else if (wr && off == 8'h0C && pwdata[0]) n_exp = 0;
        if (wr && off == 8'h00) begin
            n_en = pwdata[0]; n_ie = pwdata[1]; n_ar = pwdata[2];
            if (!m_en && pwdata[0]) begin n_cnt = m_load; n_ph = 16'd0; end
        end
        if (wr && off == 8'h04) m_load = pwdata;
        if (wr && off == 8'h10) m_pre = pwdata[15:0];
        m_en = n_en; m_ie = n_ie; m_ar = n_ar; m_exp = n_exp; m_count = n_cnt; m_ph = n_ph;
    endtask

    initial forever begin
        @(posedge pclk or negedge preset_n);
        if (!preset_n) begin
            m_en = 0; m_ie = 0; m_ar = 0; m_exp = 0; m_load = 0; m_count = 0;
            m_pre = 0; m_ph = 0; m_inx = 0; m_acc = 0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        bit edone;
        @(negedge pclk);
        edone = preset_n && m_inx && (m_acc == WS + 1);
        check("pready", {31'd0, pready}, {31'd0, edone && psel && penable});
        check("prdata", prdata, edone ? m_reg(paddr) : 32'd0);
        check("irq", {31'd0, irq}, {31'd0, m_exp && m_ie});
`ifdef APB_TIMER_PSLVERR_EN
        check("pslverr", {31'd0, pslverr}, {31'd0, edone && psel && penable && m_err(paddr, pwrite)});
`endif
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; returns at posedge+1 with the bus idle.
    task automatic apb(input logic [31:0] a, input logic [31:0] d, input bit wr, input int stall,
                       input bit abort, output logic [31:0] rd, output int lat);
        bit got;
        got = 0; rd = 32'd0; lat = -1;
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1 penable = 1;
        if (abort) begin
            @(posedge pclk); #1 psel = 0; penable = 0;
            @(posedge pclk); #1;
            return;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (pready) begin got = 1; rd = prdata; lat = i; break; end
            @(posedge pclk); #1;
        end
        check("xfer_done", {31'd0, got}, 32'd1);
        repeat (stall) begin @(posedge pclk); #1; end
        @(posedge pclk); #1 psel = 0; penable = 0;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; int lat;
        apb(a, d, 1'b1, 0, 1'b0, rd, lat);
    endtask

    task automatic rd32(input logic [31:0] a, output logic [31:0] rd);
        int lat;
        apb(a, 32'd0, 1'b0, 0, 1'b0, rd, lat);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        preset_n = 1;
        @(posedge pclk); #1;

        for (int i = 0; i <= 16; i += 4) begin
            apb(32'(i), 32'd0, 1'b0, 0, 1'b0, rd, lat);
            check("rst_reg", rd, 32'd0);
            check("pready_lat", 32'(lat), 32'(WS + 1));
        end

        // auto-reload, tick every cycle
        wr32(32'h04, 32'd5);
        wr32(32'h10, 32'd0);
        wr32(32'h00, 32'h7);
        for (int k = 0; k <= 6; k++) begin
            @(negedge pclk);
            check("ar_count", m_count, (k < 6) ? 32'(5 - k) : 32'd5);
            check("ar_irq", {31'd0, irq}, {31'd0, k == 6});
        end
        @(posedge pclk); #1;
        wr32(32'h00, 32'h0);
        wr32(32'h0C, 32'h1);

        // one-shot, prescale 3
        wr32(32'h10, 32'd3);
        wr32(32'h04, 32'd1);
        wr32(32'h00, 32'h3);
        for (int k = 0; k <= 8; k++) begin
            @(negedge pclk);
            check("os_expired", {31'd0, m_exp}, {31'd0, k == 8});
            check("os_irq", {31'd0, irq}, {31'd0, k == 8});
        end
        @(posedge pclk); #1;
        rd32(32'h00, rd); check("os_ctrl", rd, 32'h2);
        rd32(32'h08, rd); check("os_count", rd, 32'd0);
        rd32(32'h0C, rd); check("os_status", rd, 32'd1);

        // W1C racing an expiry (LOAD=0 + auto-reload expires every tick)
        wr32(32'h0C, 32'h1);
        wr32(32'h10, 32'd0);
        wr32(32'h04, 32'd0);
        wr32(32'h00, 32'h7);
        wr32(32'h0C, 32'h1);
        check("race_irq", {31'd0, irq}, 32'd1);
        rd32(32'h0C, rd); check("race_status", rd, 32'd1);
        wr32(32'h00, 32'h2);
        wr32(32'h0C, 32'h1);
        rd32(32'h0C, rd); check("w1c_status", rd, 32'd0);
        check("w1c_irq", {31'd0, irq}, 32'd0);

        // stalled completion commits once, aborted write does not commit
        apb(32'h04, 32'h11, 1'b1, 3, 1'b0, rd, lat);
        apb(32'h04, 32'h22, 1'b1, 0, 1'b1, rd, lat);
        rd32(32'h04, rd); check("abort_load", rd, 32'h11);

        // COUNT is read-only, unmapped reads 0
        wr32(32'h10, 32'd100);
        wr32(32'h04, 32'd9);
        wr32(32'h00, 32'h1);
        wr32(32'h00, 32'h0);
        wr32(32'h08, 32'hDEAD);
        rd32(32'h08, rd); check("ro_count", rd, 32'd9);
        rd32(32'h20, rd); check("unmapped", rd, 32'd0);
        wr32(32'h06, 32'hBEEF);
        rd32(32'h04, rd); check("misaligned_wr", rd, 32'd9);

        // reset asserted while DONE is presented
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h04; pwdata = 32'h33;
        @(posedge pclk); #1 penable = 1;
        repeat (WS + 1) @(posedge pclk);
        #2;
        check("pre_rst_pready", {31'd0, pready}, 32'd1);
        preset_n = 0;
        #1;
        check("mid_rst_pready", {31'd0, pready}, 32'd0);
        check("mid_rst_prdata", prdata, 32'd0);
        @(posedge pclk); #1 psel = 0; penable = 0;
        @(posedge pclk); #1 preset_n = 1;
        @(posedge pclk); #1;
        rd32(32'h04, rd); check("post_rst_load", rd, 32'd0);

        // randomized traffic, checked cycle by cycle against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d, r;
            logic [7:0]  offs [8];
            int          sel;
            offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h03};
            sel = $urandom_range(0, 7);
            r = $urandom;
            a = (r & 32'hFFFF_FF00) | {24'd0, offs[sel]};
            r = $urandom;
            case (offs[sel])
                8'h00:   d = (r & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
                8'h04:   d = 32'($urandom_range(0, 12));
                8'h10:   d = (r & 32'hFFFF_0000) | 32'($urandom_range(0, 4));
                default: d = r;
            endcase
            apb(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 2 : 0,
                ($urandom_range(0, 9) == 0), r, lat);
            repeat ($urandom_range(0, 2)) begin @(posedge pclk); #1; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB completer (slave) timer peripheral. It sits on the peripheral bus behind the CPU's APB master and is selected by that master's timer select when paddr[11:8] = 4'h0.
- Provides a prescaled 32-bit down-counter with optional auto-reload.
- Drives prdata/pready back to the master and raises a level interrupt toward the PLIC on expiry.

Parameters:
- WAIT_STATES, 1, number of ACCESS cycles with pready low before completion (0 = zero-wait); legal range 0..7.
- PRESCALE_W, 16, width of the prescaler register and counter.

Ports:
- pclk  input  1  bus and timer clock.
- preset_n  input  1  reset, active-low, asynchronous assert.
- psel  input  1  slave select from the APB master.
- penable  input  1  APB access phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  32  byte address; only paddr[7:0] is decoded, other bits ignored.
- pwdata  input  32  write data.
- prdata  output  32  read data, valid when pready=1 in ACCESS.
- pready  output  1  transfer completion.
- irq  output  1  level interrupt = STATUS.expired & CTRL.irq_en.

Behaviour:
- Clocking and reset: one clock, pclk. preset_n is asynchronous, active-low.
- Reset values: prdata=0, pready=0, irq=0, CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESCALE=0, prescaler counter=0, FSM=IDLE.
- Register map (word offsets in paddr[7:0]):
  - 0x00 CTRL, RW: bit0 enable, bit1 irq_en, bit2 auto_reload; other bits read 0.
  - 0x04 LOAD, RW, 32 bits.
  - 0x08 COUNT, RO; writes ignored.
  - 0x0C STATUS, bit0 expired; W1C.
  - 0x10 PRESCALE, RW, low PRESCALE_W bits; upper bits read 0.
  - Other offsets read 0 and writes are ignored.
- Bus FSM states: IDLE, SETUP, WAIT, DONE.
  - IDLE -> SETUP when psel & !penable.
  - SETUP -> WAIT when psel & penable and WAIT_STATES>0; SETUP -> DONE when psel & penable and WAIT_STATES=0.
  - WAIT: a wait counter loads WAIT_STATES-1 on entry and decrements each cycle. WAIT -> DONE when it reaches 0.
  - DONE -> IDLE unconditionally. The master then issues a new SETUP or stays idle.
  - Any state -> IDLE if psel=0 (aborted transfer); no register side effects.
- pready is combinational from state: 1 only in DONE and only while psel&penable. Resulting ACCESS length = WAIT_STATES+1 cycles.
- Register writes commit on the completion edge only (psel&penable&pready&pwrite). There is exactly one commit per transfer, even if the master stalls.
- prdata equals the addressed register during DONE and is 0 otherwise. The read samples register contents in the DONE cycle.
- Prescaler: when CTRL.enable=1, the prescaler counter increments each cycle. When it equals PRESCALE, it clears and a tick fires. Tick period = PRESCALE+1 cycles.
- Counter:
  - A CTRL write changing enable 0->1 loads COUNT<=LOAD and clears the prescaler.
  - On a tick with COUNT!=0, COUNT decrements by 1.
  - On a tick with COUNT==0, STATUS.expired is set. If auto_reload=1, COUNT<=LOAD. If auto_reload=0, CTRL.enable clears and COUNT holds at 0.
  - Writing LOAD while running takes effect at the next reload only.
  - enable=0 freezes COUNT and the prescaler.
- Simultaneous events:
  - An expiry in the same cycle as a STATUS W1C leaves expired=1 (set wins).
  - A CTRL write and a tick in the same cycle: the new CTRL value applies; the enable 0->1 load has priority over the decrement.
- LOAD=0 with auto_reload: expires on every tick.
- Reset mid-transfer: FSM returns to IDLE immediately, pready and prdata go to 0, and no partial write commits.

Optional Feature:
- Macro: APB_TIMER_PSLVERR_EN.
- With the macro: adds output pslverr (1 bit, reset 0). pslverr=1 together with pready in DONE for an unmapped offset, a write to COUNT, or a misaligned paddr[1:0]!=0. Writes flagged with pslverr do not commit. pslverr=0 in all other cycles.
- Without the macro: no pslverr port; these accesses complete silently (reads return 0, writes are ignored).

Test Plan:
- Reset, then read each register at 0x00-0x10 -> prdata=0, and pready rises exactly WAIT_STATES+1 cycles after penable (2 cycles at default).
- Write LOAD=5, PRESCALE=0, CTRL=0x7 -> COUNT reads 5,4,3,2,1,0 on successive cycles. Expiry occurs 6 cycles after enable, then irq=1 and COUNT=5.
- PRESCALE=3, LOAD=1, CTRL=0x3 (one-shot) -> STATUS.expired sets 8 cycles after enable. CTRL.enable then reads 0 and COUNT holds 0.
- W1C on STATUS in the same cycle as an expiry -> STATUS stays 1. A subsequent W1C of 0x1 with no expiry -> STATUS=0 and irq=0.
- Hold psel=1,penable=1 into DONE, then deassert psel mid-WAIT on a second write -> first write commits once, second write leaves the register unchanged.
- With APB_TIMER_PSLVERR_EN: write 0xDEAD to 0x08 and read 0x20 -> pslverr=1 with pready on both, and COUNT is unchanged.
